// File: rtl/imem_axi_bridge.sv
// Instruction-fetch bridge: turns single-outstanding imem requests into AXI4-Lite reads,
// maps bus responses to fault codes and drains orphaned responses after a timeout.
module imem_axi_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_rdata,
  output logic [1:0]        imem_bad,
  output logic              imem_busy,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_rready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state, state_d;
  logic              drop, drop_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [31:0]       rdata_d;
  logic [1:0]        bad_d;
  logic [ADDR_W-1:0] araddr_d;
  logic              busy_d, arvalid_d, rready_d;
  logic              accept_c;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d  = state;
    drop_d   = drop;
    cnt_d    = cnt;
    rdata_d  = imem_rdata;
    bad_d    = imem_bad;
    araddr_d = m_araddr;
    accept_c = imem_req && !imem_busy;

    // Any beat seen while a drop is pending is the orphan of a timed-out fetch.
    if (drop && m_rvalid) drop_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          araddr_d = imem_addr & WORD_MASK;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (m_arvalid && m_arready) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt + CNT_W'(1);
        if (m_rvalid && !drop) begin
          state_d = RESP;
          unique case (m_rresp)
            2'b00, 2'b01: begin rdata_d = m_rdata; bad_d = 2'b00; end
            2'b10:        begin rdata_d = '0;      bad_d = 2'b01; end
            default:      begin rdata_d = '0;      bad_d = 2'b10; end
          endcase
        end else if (cnt == CNT_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          bad_d   = 2'b11;
          drop_d  = 1'b1;
        end
      end
      RESP: begin
        if (accept_c) begin
          araddr_d = imem_addr & WORD_MASK;
          state_d  = ADDR;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == ADDR) || (state_d == DATA);
    arvalid_d = (state_d == ADDR) && !drop_d;
    rready_d  = (state_d == DATA) || drop_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      drop       <= 1'b0;
      cnt        <= '0;
      imem_rdata <= '0;
      imem_bad   <= 2'b00;
      imem_busy  <= 1'b0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_rready   <= 1'b0;
    end else begin
      state      <= state_d;
      drop       <= drop_d;
      cnt        <= cnt_d;
      imem_rdata <= rdata_d;
      imem_bad   <= bad_d;
      imem_busy  <= busy_d;
      m_arvalid  <= arvalid_d;
      m_araddr   <= araddr_d;
      m_rready   <= rready_d;
    end
  end

endmodule

// File: tb/tb_imem_axi_bridge.sv
// Directed self-checking bench for imem_axi_bridge (TIMEOUT shortened to 8).
module tb_imem_axi_bridge;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              imem_req = 1'b0;
  logic [ADDR_W-1:0] imem_addr = '0;
  logic [31:0]       imem_rdata;
  logic [1:0]        imem_bad;
  logic              imem_busy;
  logic              m_arvalid;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arready = 1'b0;
  logic              m_rvalid = 1'b0;
  logic [31:0]       m_rdata = '0;
  logic [1:0]        m_rresp = 2'b00;
  logic              m_rready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  imem_axi_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_bad(imem_bad), .imem_busy(imem_busy),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // One complete fetch starting in a cycle with busy=0; returns in the RESP cycle.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] ea,
                       input int arwait, input logic [31:0] d, input logic [1:0] rr,
                       input logic [31:0] er, input logic [1:0] eb);
    int t0;
    t0 = cyc;
    imem_req  = 1'b1;
    imem_addr = a;
    m_arready = (arwait == 0);
    step();
    imem_addr = 32'hFFFF_FFF0;
    chk({tag, "/arvalid"}, 32'(m_arvalid), 32'd1);
    chk({tag, "/araddr"}, m_araddr, ea);
    chk({tag, "/busy_addr"}, 32'(imem_busy), 32'd1);
    for (int i = 0; i < arwait; i++) begin
      step();
      chk({tag, "/arvalid_hold"}, 32'(m_arvalid), 32'd1);
      chk({tag, "/araddr_hold"}, m_araddr, ea);
      chk({tag, "/busy_hold"}, 32'(imem_busy), 32'd1);
    end
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk({tag, "/rready_data"}, 32'(m_rready), 32'd1);
    chk({tag, "/arvalid_data"}, 32'(m_arvalid), 32'd0);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rresp  = rr;
    step();
    m_rvalid = 1'b0;
    imem_req = 1'b0;
    chk({tag, "/busy_resp"}, 32'(imem_busy), 32'd0);
    chk({tag, "/rdata"}, imem_rdata, er);
    chk({tag, "/bad"}, 32'(imem_bad), 32'(eb));
    chk({tag, "/rready_resp"}, 32'(m_rready), 32'd0);
    chk({tag, "/latency"}, 32'(cyc - t0), 32'(3 + arwait));
  endtask

  initial begin
    step();
    chk("rst/busy", 32'(imem_busy), 32'd0);
    chk("rst/rdata", imem_rdata, 32'd0);
    chk("rst/bad", 32'(imem_bad), 32'd0);
    chk("rst/arvalid", 32'(m_arvalid), 32'd0);
    chk("rst/araddr", m_araddr, 32'd0);
    chk("rst/rready", 32'(m_rready), 32'd0);
    rstn = 1'b1;
    step();

    fetch("single", 32'h100, 32'h100, 0, 32'h00A0_0093, 2'b00, 32'h00A0_0093, 2'b00);
    step();

    // Back-to-back stream: each call starts in the previous RESP cycle.
    fetch("b2b0", 32'h0, 32'h0, 0, 32'h1111_0000, 2'b00, 32'h1111_0000, 2'b00);
    fetch("b2b1", 32'h4, 32'h4, 0, 32'h2222_0004, 2'b00, 32'h2222_0004, 2'b00);
    fetch("b2b2", 32'h8, 32'h8, 0, 32'h3333_0008, 2'b00, 32'h3333_0008, 2'b00);

    fetch("slverr", 32'h40, 32'h40, 20, 32'hFFFF_FFFF, 2'b10, 32'h0, 2'b01);
    fetch("decerr", 32'h44, 32'h44, 0, 32'hFFFF_FFFF, 2'b11, 32'h0, 2'b10);
    fetch("exokay", 32'h48, 32'h48, 2, 32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 2'b00);
    fetch("unalign", 32'h3, 32'h0, 0, 32'h0000_0013, 2'b00, 32'h0000_0013, 2'b00);
    step();

    // Timeout, orphan drain, then normal service.
    imem_req  = 1'b1;
    imem_addr = 32'h200;
    m_arready = 1'b1;
    step();
    imem_req = 1'b0;
    chk("to/arvalid", 32'(m_arvalid), 32'd1);
    step();
    m_arready = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      chk("to/busy_data", 32'(imem_busy), 32'd1);
      chk("to/rready_data", 32'(m_rready), 32'd1);
      step();
    end
    chk("to/busy_resp", 32'(imem_busy), 32'd0);
    chk("to/bad", 32'(imem_bad), 32'd3);
    chk("to/rdata", imem_rdata, 32'd0);
    chk("to/rready_drop", 32'(m_rready), 32'd1);
    imem_req  = 1'b1;
    imem_addr = 32'h300;
    m_arready = 1'b1;
    step();
    imem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drop/arvalid_low", 32'(m_arvalid), 32'd0);
      chk("drop/busy", 32'(imem_busy), 32'd1);
      chk("drop/rready", 32'(m_rready), 32'd1);
      step();
    end
    m_rvalid = 1'b1;
    m_rdata  = 32'hDEAD_BEEF;
    m_rresp  = 2'b00;
    step();
    m_rvalid = 1'b0;
    chk("drop/arvalid_rise", 32'(m_arvalid), 32'd1);
    chk("drop/araddr", m_araddr, 32'h300);
    chk("drop/rready_clr", 32'(m_rready), 32'd0);
    chk("drop/rdata_kept", imem_rdata, 32'd0);
    step();
    m_arready = 1'b0;
    chk("drop/rready_data", 32'(m_rready), 32'd1);
    m_rvalid = 1'b1;
    m_rdata  = 32'h1357_9BDF;
    step();
    m_rvalid = 1'b0;
    chk("drop/busy_resp", 32'(imem_busy), 32'd0);
    chk("drop/rdata", imem_rdata, 32'h1357_9BDF);
    chk("drop/bad", 32'(imem_bad), 32'd0);
    step();

    // Asynchronous reset while a response is pending in DATA.
    imem_req  = 1'b1;
    imem_addr = 32'h500;
    m_arready = 1'b1;
    step();
    imem_req = 1'b0;
    step();
    m_arready = 1'b0;
    chk("mrst/rready_pre", 32'(m_rready), 32'd1);
    m_rvalid = 1'b1;
    m_rdata  = 32'hBAD0_BAD0;
    #2 rstn = 1'b0;
    #1;
    chk("mrst/busy", 32'(imem_busy), 32'd0);
    chk("mrst/rdata", imem_rdata, 32'd0);
    chk("mrst/bad", 32'(imem_bad), 32'd0);
    chk("mrst/arvalid", 32'(m_arvalid), 32'd0);
    chk("mrst/araddr", m_araddr, 32'd0);
    chk("mrst/rready", 32'(m_rready), 32'd0);
    m_rvalid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    fetch("fresh", 32'h600, 32'h600, 0, 32'h0042_0513, 2'b00, 32'h0042_0513, 2'b00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
